// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default sizes for the memory arbiter.
//   state_e : arbiter ownership state (IDLE = no lock owner, PLOCK = programmer
//             owns the bus)
//   owner_e : identifies a requester (used for the round-robin pointer)
//   *_DEFAULT : default address width, data width and lock length
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int AW_DEFAULT       = 4;
    localparam int DW_DEFAULT       = 8;
    localparam int LOCK_MAX_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        PLOCK = 1'b1
    } state_e;

    typedef enum logic {
        CPU = 1'b0,
        PRG = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_lockcnt.sv
// ----------------------------------------------------------------------------
// mem_arb_lockcnt
// Counts the cycles the programmer has held the bus locked.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : restart the count (entry into the lock)
//   inc_i         : count this cycle (applied after clr_i, so clr_i & inc_i
//                   loads 1, i.e. the entry grant is itself a locked grant)
//   at_max_o      : this cycle's increment makes the count reach LOCK_MAX
// ----------------------------------------------------------------------------
module mem_arb_lockcnt
    import mem_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end
        if (inc_i) begin
            cnt_d = cnt_d + CW'(1);
        end
    end

    // Qualified by inc_i so a count parked at LOCK_MAX after an exit does not
    // keep reporting at_max while the arbiter sits in IDLE.
    assign at_max_o = inc_i && (cnt_d == CW'(LOCK_MAX));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Two-master arbiter (CPU reader, programmer reader/writer) for one shared
// single-port RAM with combinational read data. One access per cycle; the
// grant is combinational, read data returns registered one cycle later.
// The programmer may lock the bus for up to LOCK_MAX consecutive cycles.
//
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking in IDLE;
// otherwise the CPU has fixed priority.
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   cpu_req_i, cpu_addr_i                 CPU read request
//   cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o  CPU grant and read return
//   prg_req_i, prg_we_i, prg_addr_i,
//   prg_wdata_i, prg_lock_i               programmer request and lock
//   prg_gnt_o, prg_rvalid_o, prg_rdata_o  programmer grant and read return
//   ram_cen_o, ram_we_o, ram_addr_o,
//   ram_wdata_o, ram_rdata_i              shared RAM port
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpu_req_i,
    input  logic [AW-1:0] cpu_addr_i,
    output logic          cpu_gnt_o,
    output logic          cpu_rvalid_o,
    output logic [DW-1:0] cpu_rdata_o,
    input  logic          prg_req_i,
    input  logic          prg_we_i,
    input  logic [AW-1:0] prg_addr_i,
    input  logic [DW-1:0] prg_wdata_i,
    input  logic          prg_lock_i,
    output logic          prg_gnt_o,
    output logic          prg_rvalid_o,
    output logic [DW-1:0] prg_rdata_o,
    output logic          ram_cen_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i
);

    state_e        state_q, state_d;
    logic          cpu_win, prg_win;
    logic          cpu_wins_tie;
    logic          cnt_clr, cnt_inc, at_max;
    logic          cpu_rvalid_q, prg_rvalid_q;
    logic [DW-1:0] cpu_rdata_q, prg_rdata_q;

`ifdef MEM_ARB_RR_EN
    owner_e last_q, last_d;
    logic   force_q, force_d;

    // force_q: the lock just expired on LOCK_MAX, so the CPU must win now.
    assign cpu_wins_tie = force_q | (last_q == PRG);

    always_comb begin
        last_d = last_q;
        if (cpu_win) begin
            last_d = CPU;
        end else if (prg_win) begin
            last_d = PRG;
        end
        force_d = at_max;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q  <= CPU;
            force_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            force_q <= force_d;
        end
    end
`else
    // Fixed priority already lets the CPU win after a lock expiry.
    assign cpu_wins_tie = 1'b1;
`endif

    // Arbitration: who gets this cycle's access, and lock-counter control.
    always_comb begin
        cpu_win = 1'b0;
        prg_win = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (state_q == PLOCK) begin
            prg_win = prg_req_i;
            // Every locked cycle counts, granted or not.
            cnt_inc = 1'b1;
        end else if (cpu_req_i && prg_req_i) begin
            cpu_win = cpu_wins_tie;
            prg_win = ~cpu_wins_tie;
        end else begin
            cpu_win = cpu_req_i;
            prg_win = prg_req_i;
        end
        if ((state_q == IDLE) && prg_win && prg_lock_i) begin
            cnt_clr = 1'b1;
            cnt_inc = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // at_max here only when LOCK_MAX is 1: the lock is already spent.
                if (prg_win && prg_lock_i && !at_max) begin
                    state_d = PLOCK;
                end
            end
            PLOCK: begin
                if (!prg_lock_i || at_max) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_arb_lockcnt #(
        .LOCK_MAX(LOCK_MAX)
    ) u_lockcnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .at_max_o(at_max)
    );

    // Grants are masked by reset so every output is quiet while rst_ni is low.
    assign cpu_gnt_o   = rst_ni & cpu_win;
    assign prg_gnt_o   = rst_ni & prg_win;
    assign ram_cen_o   = cpu_gnt_o | prg_gnt_o;
    assign ram_we_o    = prg_gnt_o & prg_we_i;
    assign ram_addr_o  = prg_gnt_o ? prg_addr_i : (cpu_gnt_o ? cpu_addr_i : '0);
    assign ram_wdata_o = prg_gnt_o ? prg_wdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cpu_rvalid_q <= 1'b0;
            prg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            prg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cpu_rvalid_q <= cpu_gnt_o;
            prg_rvalid_q <= prg_gnt_o & ~prg_we_i;
            if (cpu_gnt_o) begin
                cpu_rdata_q <= ram_rdata_i;
            end
            if (prg_gnt_o && !prg_we_i) begin
                prg_rdata_q <= ram_rdata_i;
            end
        end
    end

    assign cpu_rvalid_o = cpu_rvalid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign prg_rvalid_o = prg_rvalid_q;
    assign prg_rdata_o  = prg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LM = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          prg_req = 1'b0, prg_we = 1'b0, prg_lock = 1'b0;
    logic [AW-1:0] prg_addr = '0;
    logic [DW-1:0] prg_wdata = '0;
    logic          prg_gnt, prg_rvalid;
    logic [DW-1:0] prg_rdata;
    logic          ram_cen, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    // RAM environment (the real storage the DUT drives)
    logic [DW-1:0] mem [16];
    assign ram_rdata = mem[ram_addr];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [DW-1:0] exp_mem [16];
    bit            m_locked, m_last_prg, m_force, m_cpu_pend, m_prg_pend;
    int            m_cnt;
    logic [DW-1:0] m_cpu_rd, m_prg_rd;
    bit            g_cpu, g_prg;

    logic          og_cpu [21];
    logic          og_prg [21];
    int            tally;
    bit            exp_p;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cpu_req_i   (cpu_req),
        .cpu_addr_i  (cpu_addr),
        .cpu_gnt_o   (cpu_gnt),
        .cpu_rvalid_o(cpu_rvalid),
        .cpu_rdata_o (cpu_rdata),
        .prg_req_i   (prg_req),
        .prg_we_i    (prg_we),
        .prg_addr_i  (prg_addr),
        .prg_wdata_i (prg_wdata),
        .prg_lock_i  (prg_lock),
        .prg_gnt_o   (prg_gnt),
        .prg_rvalid_o(prg_rvalid),
        .prg_rdata_o (prg_rdata),
        .ram_cen_o   (ram_cen),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: called at the falling edge with inputs already applied.
    task automatic step();
        bit            ec, ep;
        logic          s_cen, s_we;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        #1;
        if (!rst_n) begin
            m_locked = 0; m_cnt = 0; m_last_prg = 0; m_force = 0;
            m_cpu_pend = 0; m_prg_pend = 0; m_cpu_rd = '0; m_prg_rd = '0;
            ec = 0; ep = 0;
        end else if (m_locked) begin
            ec = 0; ep = prg_req;
        end else if (cpu_req && prg_req) begin
`ifdef MEM_ARB_RR_EN
            ec = m_force || m_last_prg;
`else
            ec = 1;
`endif
            ep = !ec;
        end else begin
            ec = cpu_req; ep = prg_req;
        end
        chk("cpu_gnt",    32'(cpu_gnt),    32'(ec));
        chk("prg_gnt",    32'(prg_gnt),    32'(ep));
        chk("ram_cen",    32'(ram_cen),    32'(ec | ep));
        chk("ram_we",     32'(ram_we),     32'(ep & prg_we));
        chk("ram_addr",   32'(ram_addr),   32'(ep ? prg_addr : (ec ? cpu_addr : '0)));
        chk("ram_wdata",  32'(ram_wdata),  32'(ep ? prg_wdata : '0));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_pend));
        chk("cpu_rdata",  32'(cpu_rdata),  32'(m_cpu_rd));
        chk("prg_rvalid", 32'(prg_rvalid), 32'(m_prg_pend));
        chk("prg_rdata",  32'(prg_rdata),  32'(m_prg_rd));
        g_cpu = ec; g_prg = ep;
        s_cen = ram_cen; s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata;
        @(posedge clk);
        if (rst_n) begin
            m_cpu_pend = ec;
            if (ec) m_cpu_rd = exp_mem[cpu_addr];
            m_prg_pend = ep && !prg_we;
            if (m_prg_pend) m_prg_rd = exp_mem[prg_addr];
            if (ep && prg_we) exp_mem[prg_addr] = prg_wdata;
            m_force = 0;
            if (m_locked) begin
                m_cnt++;
                if (m_cnt >= LM) begin
                    m_locked = 0;
                    m_force  = 1;
                end else if (!prg_lock) begin
                    m_locked = 0;
                end
            end else if (ep && prg_lock) begin
                m_locked = 1;
                m_cnt    = 1;
            end
            if (ec) m_last_prg = 0;
            if (ep) m_last_prg = 1;
            if (s_cen && s_we) mem[s_addr] = s_wdata;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = DW'($urandom);
            exp_mem[i] = mem[i];
        end
        mem[9] = 8'h10; exp_mem[9] = 8'h10;

        // Power-on reset
        #1 rst_n = 1'b0;
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;
        #1 chk("no_gnt_after_release", 32'(ram_cen), 32'd0);
        step();

        // CPU read of address 9
        cpu_req = 1'b1; cpu_addr = 4'h9;
        #1 chk("cpu_read_gnt", 32'(cpu_gnt), 32'd1);
        step();
        cpu_req = 1'b0;
        #1 chk("cpu_read_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("cpu_read_rdata", 32'(cpu_rdata), 32'h10);
        step();
        #1 chk("cpu_rvalid_single", 32'(cpu_rvalid), 32'd0);
        step();

        // Continuous tie
        cpu_req = 1'b1; cpu_addr = 4'h1;
        prg_req = 1'b1; prg_we = 1'b0; prg_addr = 4'h2; prg_lock = 1'b0;
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_p = (i % 2 == 0);
`else
            exp_p = 1'b0;
`endif
            #1;
            chk("tie_prg", 32'(prg_gnt), 32'(exp_p));
            chk("tie_cpu", 32'(cpu_gnt), 32'(!exp_p));
            step();
        end

        // Reset asserted mid-run during a granted read
        prg_req = 1'b0; cpu_addr = 4'h3;
        #1 chk("gnt_before_reset", 32'(cpu_gnt), 32'd1);
        rst_n = 1'b0;
        step();
        cpu_req = 1'b0;
        rst_n = 1'b1;
        #1 chk("no_rvalid_after_reset", 32'(cpu_rvalid), 32'd0);
        chk("rdata_zero_after_reset", 32'(cpu_rdata), 32'd0);
        step();

        // Programmer locked write burst with the CPU waiting
        for (int i = 0; i < 4; i++) begin
            prg_req = 1'b1; prg_we = 1'b1; prg_lock = 1'b1;
            prg_addr = AW'(i); prg_wdata = 8'hA0 + DW'(i);
            cpu_req = (i != 0); cpu_addr = 4'h5;
            #1;
            chk("burst_prg_gnt", 32'(prg_gnt), 32'd1);
            chk("burst_we", 32'(ram_we), 32'd1);
            step();
        end
        prg_req = 1'b0; prg_we = 1'b0; prg_lock = 1'b0;
        #1 chk("burst_lock_drop_cpu_wait", 32'(cpu_gnt), 32'd0);
        step();
        #1 chk("burst_cpu_after", 32'(cpu_gnt), 32'd1);
        step();
        cpu_req = 1'b0;
        prg_req = 1'b1; prg_addr = 4'h2;
        step();
        prg_req = 1'b0;
        #1;
        chk("burst_readback_vld", 32'(prg_rvalid), 32'd1);
        chk("burst_readback", 32'(prg_rdata), 32'hA2);
        step();

        // Lock starvation limit
        prg_req = 1'b1; prg_lock = 1'b1; prg_we = 1'b0; prg_addr = 4'hC;
        cpu_addr = 4'h7;
        for (int i = 0; i < 20; i++) begin
            cpu_req = (i != 0 && i != 17);
            #1;
            og_cpu[i] = cpu_gnt; og_prg[i] = prg_gnt;
            step();
        end
        tally = 0;
        for (int i = 0; i < 16; i++) tally += int'(og_prg[i]) + 2 * int'(og_cpu[i]);
        chk("starve_prg_grants", 32'(tally), 32'd16);
        chk("starve_cpu_gnt", 32'(og_cpu[16]), 32'd1);
        chk("starve_prg_held", 32'(og_prg[16]), 32'd0);
        chk("starve_prg_relock", 32'(og_prg[17]), 32'd1);
        chk("starve_plock_again", 32'(og_cpu[18]), 32'd0);
        prg_req = 1'b0; prg_lock = 1'b0; cpu_req = 1'b1;
        #1 chk("starve_drop_nogrant", 32'(cpu_gnt), 32'd0);
        step();
        #1 chk("starve_cpu_final", 32'(cpu_gnt), 32'd1);
        step();
        cpu_req = 1'b0;
        step();

        // Idle lock cycles
        for (int i = 0; i < 17; i++) begin
            prg_req = (i == 0); prg_we = 1'b1; prg_addr = 4'hF; prg_wdata = 8'h55;
            prg_lock = (i != 16);
            cpu_req = (i != 0); cpu_addr = 4'h9;
            #1;
            og_cpu[i] = cpu_gnt; og_prg[i] = prg_gnt;
            step();
        end
        tally = 0;
        for (int i = 1; i < 16; i++) tally += int'(og_prg[i]) + int'(og_cpu[i]);
        chk("idle_lock_no_grants", 32'(tally), 32'd0);
        chk("idle_lock_cpu_17", 32'(og_cpu[16]), 32'd1);
        prg_req = 1'b0; prg_we = 1'b0; prg_lock = 1'b0;
        cpu_addr = 4'hF;
        step();
        cpu_req = 1'b0;
        #1 chk("idle_lock_write_data", 32'(cpu_rdata), 32'h55);
        step();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            if (!(cpu_req && !g_cpu)) begin
                cpu_req  = ($urandom_range(0, 2) != 0);
                cpu_addr = AW'($urandom_range(0, 15));
            end
            if (!(prg_req && !g_prg)) begin
                prg_req   = ($urandom_range(0, 2) != 0);
                prg_we    = ($urandom_range(0, 1) == 1);
                prg_addr  = AW'($urandom_range(0, 15));
                prg_wdata = DW'($urandom);
                prg_lock  = (i % 64 < 32) ? ($urandom_range(0, 15) != 0)
                                          : ($urandom_range(0, 3) == 0);
            end
            step();
        end
        cpu_req = 1'b0; prg_req = 1'b0; prg_lock = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
